// File: rtl/ccd_timing_pkg.sv
// rtl/ccd_timing_pkg.sv - shared state type and pixel-phase constants for the CCD timing generator
package ccd_timing_pkg;

  typedef enum logic [1:0] {IDLE, SH, READ} state_e;

  localparam logic [15:0] RS_START   = 16'd0;
  localparam logic [15:0] RS_END     = 16'd3;
  localparam logic [15:0] CP_START   = 16'd4;
  localparam logic [15:0] CP_END     = 16'd7;
  localparam logic [15:0] P1_END     = 16'd31;
  localparam logic [15:0] CS_LO      = 16'd20;
  localparam logic [15:0] CS_HI      = 16'd56;
  localparam logic [15:0] SCLK_START = 16'd22;
  localparam logic [15:0] SCLK_END   = SCLK_START + 16'd30;
  localparam logic [15:0] PIX_STB    = 16'd56;
  localparam logic [15:0] STB_LEN    = 16'd4;

  function automatic logic in_range(input logic [15:0] v, input logic [15:0] lo,
                                    input logic [15:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // sclk pulses land on even phases because SCLK_START is even
  function automatic logic sclk_phase(input logic [15:0] p);
    return in_range(p, SCLK_START, SCLK_END) && !p[0];
  endfunction

endpackage

// File: rtl/ccd_timing_adc_rx.sv
// rtl/ccd_timing_adc_rx.sv - ADC chip select, serial clock and MSB-first shift-in per pixel
module ccd_adc_rx
  import ccd_timing_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        act_i,
  input  logic [15:0] phase_i,
  input  logic        act_nxt_i,
  input  logic [15:0] phase_nxt_i,
  input  logic        sdo_i,
  output logic        cs_o,
  output logic        sclk_o,
  output logic [15:0] sr_o,
  output logic        done_o
);

  logic        cs_q;
  logic        sclk_q;
  logic        done_q;
  logic [15:0] sr_q;

  // cs/sclk are decoded from the next phase so the registered pins line up with phase_i
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cs_q   <= 1'b1;
      sclk_q <= 1'b0;
      sr_q   <= 16'h0000;
      done_q <= 1'b0;
    end else begin
      cs_q   <= !(act_nxt_i && in_range(phase_nxt_i, CS_LO, CS_HI - 16'd1));
      sclk_q <= act_nxt_i && sclk_phase(phase_nxt_i);
      if (act_i && sclk_phase(phase_i)) begin
        sr_q <= {sr_q[14:0], sdo_i};
      end
      if (act_i && (phase_i == SCLK_END)) begin
        done_q <= 1'b1;
      end else if (!act_nxt_i || (phase_nxt_i == 16'd0)) begin
        done_q <= 1'b0;
      end
    end
  end

  assign cs_o   = cs_q;
  assign sclk_o = sclk_q;
  assign sr_o   = sr_q;
  assign done_o = done_q;

endmodule

// File: rtl/ccd_timing.sv
// rtl/ccd_timing.sv - line FSM, pixel/phase counters and CCD waveforms for a two-phase linear CCD
module ccd_timing
  import ccd_timing_pkg::*;
#(
  parameter int PIX_CLKS = 64,
  parameter int N_PIX    = 2100,
  parameter int SH_CLKS  = 80,
  parameter int SH_GUARD = 16
) (
  input  logic        clk_80M,
  input  logic        rst_n,
  input  logic        en,
  input  logic        cal_mode,
  output logic        ccd_p1,
  output logic        ccd_p2,
  output logic        ccd_sh,
  output logic        ccd_rs,
  output logic        ccd_cp,
  output logic        adc_cs,
  output logic        adc_sclk,
  input  logic        adc_sdo,
  output logic        pix_clk,
  output logic [15:0] pix_data
);

  localparam logic [15:0] SH_LAST  = 16'(2 * SH_GUARD + SH_CLKS - 1);
  localparam logic [15:0] SH_ON    = 16'(SH_GUARD);
  localparam logic [15:0] SH_OFF   = 16'(SH_GUARD + SH_CLKS - 1);
  localparam logic [15:0] PIX_LAST = 16'(PIX_CLKS - 1);
  localparam logic [15:0] LAST_PIX = 16'(N_PIX - 1);

  state_e      state_q, state_d;
  logic [15:0] c_q, c_d;
  logic [15:0] pix_q, pix_d;
  logic        cal_q, cal_d;

  logic        p1_q, p1_d;
  logic        p2_q, p2_d;
  logic        sh_q, sh_d;
  logic        rs_q, rs_d;
  logic        cp_q, cp_d;
  logic        pclk_q, pclk_d;
  logic [15:0] pix_data_q;
  logic        rd_d;
  logic        ld_d;

  logic        adc_done;
  logic [15:0] adc_sr;

  // c counts SH-phase clocks in SH and the pixel phase in READ
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    pix_d   = pix_q;
    cal_d   = cal_q;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = SH;
          c_d     = 16'd0;
          cal_d   = cal_mode;
        end
      end
      SH: begin
        if (c_q == SH_LAST) begin
          state_d = READ;
          c_d     = 16'd0;
          pix_d   = 16'd0;
        end else begin
          c_d = c_q + 16'd1;
        end
      end
      READ: begin
        if (c_q == PIX_LAST) begin
          c_d = 16'd0;
          if (pix_q == LAST_PIX) begin
            if (en) begin
              state_d = SH;
              cal_d   = cal_mode;
            end else begin
              state_d = IDLE;
            end
          end else begin
            pix_d = pix_q + 16'd1;
          end
        end else begin
          c_d = c_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    rd_d   = (state_d == READ);
    p1_d   = !rd_d || (c_d <= P1_END);
    p2_d   = !p1_d;
    sh_d   = (state_d == SH) && in_range(c_d, SH_ON, SH_OFF);
    rs_d   = rd_d && (c_d <= RS_END);
    cp_d   = rd_d && in_range(c_d, CP_START, CP_END);
    pclk_d = rd_d && in_range(c_d, PIX_STB, PIX_STB + STB_LEN - 16'd1);
    ld_d   = rd_d && (c_d == PIX_STB) && (cal_q || adc_done);
  end

  always_ff @(posedge clk_80M or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      c_q        <= 16'd0;
      pix_q      <= 16'd0;
      cal_q      <= 1'b0;
      p1_q       <= 1'b1;
      p2_q       <= 1'b0;
      sh_q       <= 1'b0;
      rs_q       <= 1'b0;
      cp_q       <= 1'b0;
      pclk_q     <= 1'b0;
      pix_data_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      pix_q   <= pix_d;
      cal_q   <= cal_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      sh_q    <= sh_d;
      rs_q    <= rs_d;
      cp_q    <= cp_d;
      pclk_q  <= pclk_d;
      if (ld_d) begin
        pix_data_q <= cal_q ? pix_q : adc_sr;
      end
    end
  end

  ccd_adc_rx u_adc_rx (
    .clk_i       (clk_80M),
    .rst_n_i     (rst_n),
    .act_i       (state_q == READ),
    .phase_i     (c_q),
    .act_nxt_i   (rd_d),
    .phase_nxt_i (c_d),
    .sdo_i       (adc_sdo),
    .cs_o        (adc_cs),
    .sclk_o      (adc_sclk),
    .sr_o        (adc_sr),
    .done_o      (adc_done)
  );

  assign ccd_p1   = p1_q;
  assign ccd_p2   = p2_q;
  assign ccd_sh   = sh_q;
  assign ccd_rs   = rs_q;
  assign ccd_cp   = cp_q;
  assign pix_clk  = pclk_q;
  assign pix_data = pix_data_q;

endmodule

// File: tb/tb_ccd_timing.sv
// tb/tb_ccd_timing.sv - bench for ccd_timing against a line-timeline reference model
module tb_ccd_timing;

  localparam int NP       = 40;
  localparam int PIX      = 64;
  localparam int SH_CLKS  = 80;
  localparam int SH_GUARD = 16;
  localparam int HDR      = 2 * SH_GUARD + SH_CLKS;
  localparam int LINE     = HDR + NP * PIX;

  logic        clk_80M = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        cal_mode = 1'b0;
  logic        adc_sdo = 1'b0;
  logic        ccd_p1, ccd_p2, ccd_sh, ccd_rs, ccd_cp;
  logic        adc_cs, adc_sclk, pix_clk;
  logic [15:0] pix_data;

  ccd_timing #(.PIX_CLKS(PIX), .N_PIX(NP), .SH_CLKS(SH_CLKS), .SH_GUARD(SH_GUARD)) dut (
    .clk_80M  (clk_80M),
    .rst_n    (rst_n),
    .en       (en),
    .cal_mode (cal_mode),
    .ccd_p1   (ccd_p1),
    .ccd_p2   (ccd_p2),
    .ccd_sh   (ccd_sh),
    .ccd_rs   (ccd_rs),
    .ccd_cp   (ccd_cp),
    .adc_cs   (adc_cs),
    .adc_sclk (adc_sclk),
    .adc_sdo  (adc_sdo),
    .pix_clk  (pix_clk),
    .pix_data (pix_data)
  );

  always #6 clk_80M = ~clk_80M;

  int          checks = 0;
  int          errors = 0;
  int          t = 0;
  bit          m_idle = 1'b1;
  bit          m_cal = 1'b0;
  int          mode = 0;
  logic [15:0] word = 16'h0000;
  logic [15:0] exp_pd = 16'h0000;
  int          cyc = 0;
  int          strobes = 0;
  int          last_rise = -1;
  bit          prev_pclk = 1'b0;
  bit          prev_sh = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d obs=%h exp=%h", tag, t, obs, exp);
    end
  endtask

  // {p1,p2,sh,rs,cp,cs,sclk,pix_clk} at clock tt of a line
  function automatic logic [7:0] exp_wave(input bit idle, input int tt);
    int c;
    logic p1, sh, rs, cp, cs, sc, pc;
    p1 = 1; sh = 0; rs = 0; cp = 0; cs = 1; sc = 0; pc = 0;
    if (!idle) begin
      if (tt < HDR) begin
        sh = (tt >= SH_GUARD) && (tt < SH_GUARD + SH_CLKS);
      end else begin
        c  = (tt - HDR) % PIX;
        p1 = (c < 32);
        rs = (c < 4);
        cp = (c >= 4) && (c < 8);
        cs = !((c >= 20) && (c < 56));
        sc = (c >= 22) && (c <= 52) && (c % 2 == 0);
        pc = (c >= 56) && (c < 60);
      end
    end
    return {p1, !p1, sh, rs, cp, cs, sc, pc};
  endfunction

  function automatic logic [15:0] next_word();
    if (mode == 0) return 16'hA5C3;
    if (mode == 1) return 16'hFFFF;
    return 16'($urandom);
  endfunction

  task automatic step(input int n);
    int mc, mp, k;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_80M);
      cyc++;
      if (!rst_n) begin
        m_idle = 1'b1;
      end else if (m_idle) begin
        if (en) begin
          m_idle = 1'b0;
          t      = 0;
          m_cal  = cal_mode;
        end
      end else if (t == LINE - 1) begin
        if (en) begin
          t     = 0;
          m_cal = cal_mode;
        end else begin
          m_idle = 1'b1;
        end
      end else begin
        t++;
      end
      mc = -1;
      if (!m_idle && t >= HDR) begin
        mc = (t - HDR) % PIX;
        mp = (t - HDR) / PIX;
        if (mc == 0) word = next_word();
        if (mc == 56) exp_pd = m_cal ? 16'(mp) : word;
      end
      if (!rst_n) exp_pd = 16'h0000;

      @(negedge clk_80M);
      chk("wave", {8'h00, ccd_p1, ccd_p2, ccd_sh, ccd_rs, ccd_cp, adc_cs, adc_sclk, pix_clk},
          {8'h00, exp_wave(m_idle, t)});
      chk("pix_data", pix_data, exp_pd);

      if (!m_idle && t == 0) strobes = 0;
      if (pix_clk && !prev_pclk) strobes++;
      if (!m_idle && t == LINE - 1) chk("strobes", 16'(strobes), 16'(NP));
      if (m_idle) last_rise = -1;
      if (ccd_sh && !prev_sh) begin
        if (last_rise >= 0) chk("sh_period", 16'(cyc - last_rise), 16'(LINE));
        last_rise = cyc;
      end
      prev_pclk = pix_clk;
      prev_sh   = ccd_sh;

      if (mc >= 22 && mc <= 52 && (mc % 2 == 0)) begin
        k = 15 - (mc - 22) / 2;
        adc_sdo = word[k];
      end else begin
        adc_sdo = (mode == 1) ? 1'b1 : 1'($urandom);
      end
    end
  endtask

  task automatic run_to_pixel(input int p);
    int n;
    n = 0;
    while (!(!m_idle && t == HDR + p * PIX) && n < 3 * LINE) begin
      step(1);
      n++;
    end
    chk("run_to_pixel", 16'(n < 3 * LINE), 16'd1);
  endtask

  initial begin
    // reset held, then idle with en low
    step(5);
    rst_n = 1'b1;
    step(1000);

    // fixed ADC word
    mode = 0;
    en   = 1'b1;
    step(LINE + 10);

    // sdo tied high
    mode = 1;
    step(LINE);

    // random words; cal_mode raised mid-line must only take effect at the next SH
    mode = 2;
    step(LINE / 2);
    cal_mode = 1'b1;
    step(LINE / 2 + 20);
    step(LINE);

    // en dropped mid-line: line completes, then idle
    run_to_pixel(20);
    en = 1'b0;
    step(LINE);

    // async reset mid-pixel
    cal_mode = 1'b0;
    en       = 1'b1;
    step(300);
    #3 rst_n = 1'b0;
    #1;
    exp_pd = 16'h0000;
    m_idle = 1'b1;
    chk("rst_wave", {8'h00, ccd_p1, ccd_p2, ccd_sh, ccd_rs, ccd_cp, adc_cs, adc_sclk, pix_clk},
        16'h0084);
    chk("rst_pix", pix_data, 16'h0000);
    step(3);
    en    = 1'b0;
    rst_n = 1'b1;
    step(50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
